// File: rtl/mem_2_to_1_arbiter.sv
// Round-robin arbiter sharing one memory_2_to_1_wrapper between two requesters,
// with locked bursts and one-cycle read response tracking. Build option: MEM_ARB_FIXED_PRIORITY_EN.
module mem_2_to_1_arbiter #(
   parameter int WIDTH            = 64,
   parameter int SINGLE_MEM_DEPTH = 7,
   parameter int ADDR_W           = $clog2(SINGLE_MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_0_valid,
   input  logic              req_0_we,
   input  logic [ADDR_W-1:0] req_0_addr,
   input  logic [WIDTH-1:0]  req_0_din,
   input  logic              req_0_last,
   output logic              req_0_ready,
   input  logic              req_1_valid,
   input  logic              req_1_we,
   input  logic [ADDR_W-1:0] req_1_addr,
   input  logic [WIDTH-1:0]  req_1_din,
   input  logic              req_1_last,
   output logic              req_1_ready,
   output logic              rsp_0_valid,
   output logic [WIDTH-1:0]  rsp_0_dout,
   output logic              rsp_1_valid,
   output logic [WIDTH-1:0]  rsp_1_dout,
   output logic              mem_0_wr_en,
   output logic [ADDR_W-1:0] mem_0_wr_addr,
   output logic [WIDTH-1:0]  mem_0_din,
   output logic              mem_0_rd_en,
   output logic [ADDR_W-1:0] mem_0_rd_addr,
   output logic              mem_1_wr_en,
   output logic [ADDR_W-1:0] mem_1_wr_addr,
   output logic [WIDTH-1:0]  mem_1_din,
   output logic              mem_1_rd_en,
   output logic [ADDR_W-1:0] mem_1_rd_addr,
   input  logic [WIDTH-1:0]  mem_dout
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

   state_t state_q, state_d;
   logic   prio_q, prio_d;
   logic   rd_pend_q, rd_pend_d;
   logic   rd_owner_q, rd_owner_d;
   logic   rd_oor_q, rd_oor_d;

   logic              fire;
   logic              sel_we;
   logic              sel_last;
   logic [ADDR_W-1:0] sel_addr;
   logic [WIDTH-1:0]  sel_din;
   logic              sel_oor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
         rd_oor_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         rd_oor_q   <= rd_oor_d;
      end
   end

   // Grants are valid-qualified, so ready doubles as the per-requester fire strobe.
   always_comb begin
      req_0_ready = 1'b0;
      req_1_ready = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (req_0_valid && (!req_1_valid || !prio_q)) req_0_ready = 1'b1;
               else if (req_1_valid)                          req_1_ready = 1'b1;
            end
            LOCK0:   req_0_ready = req_0_valid;
            LOCK1:   req_1_ready = req_1_valid;
            default: ;
         endcase
      end
   end

   always_comb begin
      fire     = req_0_ready | req_1_ready;
      sel_we   = req_1_ready ? req_1_we   : req_0_we;
      sel_last = req_1_ready ? req_1_last : req_0_last;
      sel_addr = req_1_ready ? req_1_addr : req_0_addr;
      sel_din  = req_1_ready ? req_1_din  : req_0_din;
      sel_oor  = 32'(sel_addr) >= SINGLE_MEM_DEPTH;
   end

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      if (fire) begin
         if (sel_last) begin
            state_d = IDLE;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            prio_d  = 1'b0;
`else
            prio_d  = req_0_ready;
`endif
         end else begin
            state_d = req_1_ready ? LOCK1 : LOCK0;
         end
      end
      rd_pend_d  = fire && !sel_we;
      rd_owner_d = req_1_ready;
      rd_oor_d   = sel_oor;
   end

   // Out-of-range beats are accepted but never reach the wrapper.
   always_comb begin
      mem_0_wr_en   = 1'b0;
      mem_0_wr_addr = '0;
      mem_0_din     = '0;
      mem_0_rd_en   = 1'b0;
      mem_0_rd_addr = '0;
      mem_1_wr_en   = 1'b0;
      mem_1_wr_addr = '0;
      mem_1_din     = '0;
      mem_1_rd_en   = 1'b0;
      mem_1_rd_addr = '0;
      if (fire && !sel_oor) begin
         if (req_0_ready) begin
            if (sel_we) begin
               mem_0_wr_en   = 1'b1;
               mem_0_wr_addr = sel_addr;
               mem_0_din     = sel_din;
            end else begin
               mem_0_rd_en   = 1'b1;
               mem_0_rd_addr = sel_addr;
            end
         end else begin
            if (sel_we) begin
               mem_1_wr_en   = 1'b1;
               mem_1_wr_addr = sel_addr;
               mem_1_din     = sel_din;
            end else begin
               mem_1_rd_en   = 1'b1;
               mem_1_rd_addr = sel_addr;
            end
         end
      end
   end

   always_comb begin
      rsp_0_valid = rd_pend_q && !rd_owner_q;
      rsp_1_valid = rd_pend_q &&  rd_owner_q;
      rsp_0_dout  = (rsp_0_valid && !rd_oor_q) ? mem_dout : '0;
      rsp_1_dout  = (rsp_1_valid && !rd_oor_q) ? mem_dout : '0;
   end

endmodule

// File: tb/tb_mem_2_to_1_arbiter.sv
// Directed bench for mem_2_to_1_arbiter with a two-region single-port memory model;
// expectations follow MEM_ARB_FIXED_PRIORITY_EN when it is defined.
module tb_mem_2_to_1_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_0_valid, req_0_we, req_0_last, req_0_ready;
   logic [2:0]  req_0_addr;
   logic [63:0] req_0_din;
   logic        req_1_valid, req_1_we, req_1_last, req_1_ready;
   logic [2:0]  req_1_addr;
   logic [63:0] req_1_din;
   logic        rsp_0_valid, rsp_1_valid;
   logic [63:0] rsp_0_dout, rsp_1_dout;
   logic        mem_0_wr_en, mem_0_rd_en, mem_1_wr_en, mem_1_rd_en;
   logic [2:0]  mem_0_wr_addr, mem_0_rd_addr, mem_1_wr_addr, mem_1_rd_addr;
   logic [63:0] mem_0_din, mem_1_din;
   logic [63:0] mem_dout;

   logic [63:0] region0 [0:7];
   logic [63:0] region1 [0:7];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_2_to_1_arbiter dut (
      .clk(clk), .rst(rst),
      .req_0_valid(req_0_valid), .req_0_we(req_0_we), .req_0_addr(req_0_addr),
      .req_0_din(req_0_din), .req_0_last(req_0_last), .req_0_ready(req_0_ready),
      .req_1_valid(req_1_valid), .req_1_we(req_1_we), .req_1_addr(req_1_addr),
      .req_1_din(req_1_din), .req_1_last(req_1_last), .req_1_ready(req_1_ready),
      .rsp_0_valid(rsp_0_valid), .rsp_0_dout(rsp_0_dout),
      .rsp_1_valid(rsp_1_valid), .rsp_1_dout(rsp_1_dout),
      .mem_0_wr_en(mem_0_wr_en), .mem_0_wr_addr(mem_0_wr_addr), .mem_0_din(mem_0_din),
      .mem_0_rd_en(mem_0_rd_en), .mem_0_rd_addr(mem_0_rd_addr),
      .mem_1_wr_en(mem_1_wr_en), .mem_1_wr_addr(mem_1_wr_addr), .mem_1_din(mem_1_din),
      .mem_1_rd_en(mem_1_rd_en), .mem_1_rd_addr(mem_1_rd_addr),
      .mem_dout(mem_dout)
   );

   // Wrapper model: one access per cycle, registered read data.
   always @(posedge clk) begin
      if (mem_0_wr_en) region0[mem_0_wr_addr] = mem_0_din;
      if (mem_1_wr_en) region1[mem_1_wr_addr] = mem_1_din;
      if (mem_0_rd_en)      mem_dout <= region0[mem_0_rd_addr];
      else if (mem_1_rd_en) mem_dout <= region1[mem_1_rd_addr];
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else begin
         n_pass++;
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic drv0(input logic v, input logic we, input logic [2:0] a,
                       input logic [63:0] d, input logic l);
      req_0_valid = v; req_0_we = we; req_0_addr = a; req_0_din = d; req_0_last = l;
   endtask

   task automatic drv1(input logic v, input logic we, input logic [2:0] a,
                       input logic [63:0] d, input logic l);
      req_1_valid = v; req_1_we = we; req_1_addr = a; req_1_din = d; req_1_last = l;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic g, pg;

   initial begin
      for (int i = 0; i < 8; i++) begin
         region0[i] = 64'h1000 + 64'(i);
         region1[i] = 64'h2000 + 64'(i);
      end
      mem_dout = '0;
      rst = 1'b1;
      drv0(1, 0, 3'd0, 64'h0, 1);
      drv1(1, 0, 3'd0, 64'h0, 1);

      // Reset holds everything quiet even with both requesters valid.
      @(negedge clk);
      check_val("rst_ready0", req_0_ready, 0);
      check_val("rst_ready1", req_1_ready, 0);
      check_val("rst_rd0_en", mem_0_rd_en, 0);
      check_val("rst_rd1_en", mem_1_rd_en, 0);
      check_val("rst_rsp_v",  {rsp_0_valid, rsp_1_valid}, 0);
      next_cycle();
      rst = 1'b0;

      // Contention: single-beat reads, addr 0..3.
      pg = 1'b0;
      for (int c = 0; c < 5; c++) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
         g = 1'b0;
`else
         g = c[0];
`endif
         if (c < 4) begin
            drv0(1, 0, 3'(c), 64'h0, 1);
            drv1(1, 0, 3'(c), 64'h0, 1);
         end else begin
            drv0(0, 0, 3'd0, 64'h0, 1);
            drv1(0, 0, 3'd0, 64'h0, 1);
         end
         @(negedge clk);
         if (c < 4) begin
            check_val($sformatf("cont%0d_ready0", c), req_0_ready, !g);
            check_val($sformatf("cont%0d_ready1", c), req_1_ready, g);
            check_val($sformatf("cont%0d_rd0_en", c), mem_0_rd_en, !g);
            check_val($sformatf("cont%0d_rd1_en", c), mem_1_rd_en, g);
            check_val($sformatf("cont%0d_rd_addr", c), g ? mem_1_rd_addr : mem_0_rd_addr, 3'(c));
         end
         if (c > 0) begin
            check_val($sformatf("cont%0d_rsp0_v", c), rsp_0_valid, !pg);
            check_val($sformatf("cont%0d_rsp1_v", c), rsp_1_valid, pg);
            check_val($sformatf("cont%0d_rsp_dout", c), pg ? rsp_1_dout : rsp_0_dout,
                      (pg ? 64'h2000 : 64'h1000) + 64'(c - 1));
         end
         pg = g;
         next_cycle();
      end

      // Burst lock: req0 writes 0..3, req1 blocked until the last beat.
      for (int k = 0; k < 6; k++) begin
         if (k < 4) drv0(1, 1, 3'(k), 64'hA0 + 64'(k), k == 3);
         else       drv0(0, 0, 3'd0, 64'h0, 1);
         if (k < 5) drv1(1, 0, 3'd5, 64'h0, 1);
         else       drv1(0, 0, 3'd0, 64'h0, 1);
         @(negedge clk);
         if (k < 4) begin
            check_val($sformatf("burst%0d_ready0", k), req_0_ready, 1);
            check_val($sformatf("burst%0d_ready1", k), req_1_ready, 0);
            check_val($sformatf("burst%0d_wr_en", k), mem_0_wr_en, 1);
            check_val($sformatf("burst%0d_wr_addr", k), mem_0_wr_addr, 3'(k));
            check_val($sformatf("burst%0d_din", k), mem_0_din, 64'hA0 + 64'(k));
         end else if (k == 4) begin
            check_val("burst4_ready1", req_1_ready, 1);
            check_val("burst4_rd1_addr", mem_1_rd_addr, 3'd5);
         end else begin
            check_val("burst5_rsp1_v", rsp_1_valid, 1);
            check_val("burst5_rsp1_dout", rsp_1_dout, 64'h2005);
         end
         next_cycle();
      end

      // Burst with a one-cycle valid gap keeps req1 locked out.
      drv0(1, 1, 3'd4, 64'hA4, 0); drv1(1, 0, 3'd6, 64'h0, 1);
      @(negedge clk);
      check_val("gap0_ready0", req_0_ready, 1);
      check_val("gap0_ready1", req_1_ready, 0);
      next_cycle();
      drv0(0, 0, 3'd0, 64'h0, 1);
      @(negedge clk);
      check_val("gap1_ready1", req_1_ready, 0);
      check_val("gap1_enables", {mem_0_wr_en, mem_0_rd_en, mem_1_wr_en, mem_1_rd_en}, 0);
      next_cycle();
      drv0(1, 1, 3'd5, 64'hA5, 1);
      @(negedge clk);
      check_val("gap2_ready0", req_0_ready, 1);
      check_val("gap2_ready1", req_1_ready, 0);
      next_cycle();
      drv0(0, 0, 3'd0, 64'h0, 1);
      @(negedge clk);
      check_val("gap3_ready1", req_1_ready, 1);
      next_cycle();
      drv1(0, 0, 3'd0, 64'h0, 1);
      drv0(1, 0, 3'd3, 64'h0, 1);
      @(negedge clk);
      check_val("gap4_rsp1_dout", rsp_1_dout, 64'h2006);
      check_val("rb0_ready0", req_0_ready, 1);
      next_cycle();
      drv0(1, 0, 3'd4, 64'h0, 1);
      @(negedge clk);
      check_val("rb1_rsp0_dout", rsp_0_dout, 64'hA3);
      next_cycle();
      drv0(0, 0, 3'd0, 64'h0, 1);
      @(negedge clk);
      check_val("rb2_rsp0_v", rsp_0_valid, 1);
      check_val("rb2_rsp0_dout", rsp_0_dout, 64'hA4);
      next_cycle();

      // Write then read of the same address by req1.
      drv1(1, 1, 3'd6, 64'hDEADBEEF, 1);
      @(negedge clk);
      check_val("wr_ready1", req_1_ready, 1);
      check_val("wr_wr1_en", mem_1_wr_en, 1);
      check_val("wr_wr1_addr", mem_1_wr_addr, 3'd6);
      check_val("wr_din1", mem_1_din, 64'hDEADBEEF);
      next_cycle();
      drv1(1, 0, 3'd6, 64'h0, 1);
      @(negedge clk);
      check_val("wr_rd1_en", mem_1_rd_en, 1);
      check_val("wr_rd1_addr", mem_1_rd_addr, 3'd6);
      next_cycle();
      drv1(0, 0, 3'd0, 64'h0, 1);
      @(negedge clk);
      check_val("wr_rsp1_v", rsp_1_valid, 1);
      check_val("wr_rsp1_dout", rsp_1_dout, 64'hDEADBEEF);
      check_val("wr_rsp0_v", rsp_0_valid, 0);
      next_cycle();

      // Out-of-range accesses are accepted but never issued.
      drv0(1, 0, 3'd7, 64'h0, 1);
      @(negedge clk);
      check_val("oor_rd_ready0", req_0_ready, 1);
      check_val("oor_rd0_en", mem_0_rd_en, 0);
      next_cycle();
      drv0(1, 1, 3'd7, 64'h55, 1);
      @(negedge clk);
      check_val("oor_rsp0_v", rsp_0_valid, 1);
      check_val("oor_rsp0_dout", rsp_0_dout, 64'h0);
      check_val("oor_wr_ready0", req_0_ready, 1);
      check_val("oor_wr0_en", mem_0_wr_en, 0);
      next_cycle();
      drv0(0, 0, 3'd0, 64'h0, 1);
      @(negedge clk);
      check_val("oor_wr_rsp0_v", rsp_0_valid, 0);
      next_cycle();

      // Reset in the cycle after a locking read discards it and returns to IDLE.
      drv1(1, 0, 3'd2, 64'h0, 0);
      @(negedge clk);
      check_val("mrst_ready1", req_1_ready, 1);
      next_cycle();
      rst = 1'b1;
      drv0(1, 0, 3'd0, 64'h0, 1);
      drv1(1, 0, 3'd2, 64'h0, 1);
      @(negedge clk);
      check_val("mrst_rsp1_v", rsp_1_valid, 0);
      check_val("mrst_ready", {req_0_ready, req_1_ready}, 0);
      check_val("mrst_rd1_en", mem_1_rd_en, 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_ready0", req_0_ready, 1);
      check_val("post_rst_ready1", req_1_ready, 0);
      next_cycle();
      drv0(0, 0, 3'd0, 64'h0, 1);
      drv1(0, 0, 3'd0, 64'h0, 1);
      @(negedge clk);
      check_val("post_rst_rsp0_dout", rsp_0_dout, 64'hA0);
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
